// File: rtl/nsw_bbm_ctrl.sv
// Break-before-make sequencer driving the SW pins of an N:1 bank of nsw1 pass switches.
// Optional macro NSW_BBM_SETTLE_EN adds a post-make settle interval before DONE.
module nsw_bbm_ctrl #(
    parameter int N      = 4,
    parameter int SELW   = 2,
    parameter int DEAD   = 3,
    parameter int SETTLE = 2
) (
    input  logic            CLK,
    input  logic            RSTN,
    input  logic            REQ_VALID,
    output logic            REQ_READY,
    input  logic [SELW-1:0] REQ_SEL,
    input  logic            REQ_OFF,
    output logic [N-1:0]    SW,
    output logic            BUSY,
    output logic            DONE,
    output logic            ERR
);
    localparam int DEAD_C   = (DEAD < 1) ? 1 : DEAD;
    localparam int SETTLE_C = (SETTLE < 1) ? 1 : SETTLE;
    localparam int CNT_MAX  = (DEAD_C > SETTLE_C) ? DEAD_C : SETTLE_C;
    localparam int CNTW     = $clog2(CNT_MAX + 1);

    localparam logic [1:0]      S_IDLE  = 2'd0;
    localparam logic [1:0]      S_BREAK = 2'd1;
`ifdef NSW_BBM_SETTLE_EN
    localparam logic [1:0]      S_SETTLE  = 2'd2;
    localparam logic [CNTW-1:0] SETTLE_LD = CNTW'(SETTLE_C - 1);
`endif
    localparam logic [CNTW-1:0] DEAD_LD = CNTW'(DEAD_C - 1);
    localparam logic [SELW:0]   N_LIM   = (SELW + 1)'(N);
    localparam logic [N-1:0]    ONE     = N'(1);

    logic [1:0]      state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [N-1:0]    sw_q, sw_d;
    logic [N-1:0]    tgt_q, tgt_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            sel_bad;
    logic [N-1:0]    req_tgt;

    always_comb begin
        sel_bad = ({1'b0, REQ_SEL} >= N_LIM);
        req_tgt = '0;
        if (!REQ_OFF && !sel_bad) begin
            req_tgt = ONE << REQ_SEL;
        end
    end

    // The make step happens on the edge that leaves BREAK; SW is never written
    // with a non-zero value except from the all-open state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sw_d    = sw_q;
        tgt_d   = tgt_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (REQ_VALID) begin
                    if (!REQ_OFF && sel_bad) begin
                        err_d  = 1'b1;
                        done_d = 1'b1;
                    end else if (req_tgt == sw_q) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_BREAK;
                        sw_d    = '0;
                        tgt_d   = req_tgt;
                        cnt_d   = DEAD_LD;
                    end
                end
            end
            S_BREAK: begin
                if (cnt_q == '0) begin
                    sw_d = tgt_q;
`ifdef NSW_BBM_SETTLE_EN
                    state_d = S_SETTLE;
                    cnt_d   = SETTLE_LD;
`else
                    state_d = S_IDLE;
                    done_d  = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q - CNTW'(1);
                end
            end
`ifdef NSW_BBM_SETTLE_EN
            S_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNTW'(1);
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
                sw_d    = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sw_q    <= '0;
            tgt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sw_q    <= sw_d;
            tgt_q   <= tgt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign SW        = sw_q;
    assign BUSY      = (state_q != S_IDLE);
    assign REQ_READY = ~BUSY;
    assign DONE      = done_q;
    assign ERR       = err_q;

endmodule

// File: tb/tb_nsw_bbm_ctrl.sv
// Bench for nsw_bbm_ctrl: directed and random requests against a timeline model
// that predicts every output cycle by cycle from the accept edge.
module tb_nsw_bbm_ctrl;
    localparam int N      = 4;
    localparam int SELW   = 3;
    localparam int DEAD   = 3;
    localparam int SETTLE = 2;
    localparam int DEAD_E = (DEAD < 1) ? 1 : DEAD;
`ifdef NSW_BBM_SETTLE_EN
    localparam int SET_E  = (SETTLE < 1) ? 1 : SETTLE;
`else
    localparam int SET_E  = 0;
`endif

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [SELW-1:0] req_sel = '0;
    logic            req_off = 1'b0;
    logic [N-1:0]    sw;
    logic            busy;
    logic            done;
    logic            err;

    always #5 clk = ~clk;

    nsw_bbm_ctrl #(.N(N), .SELW(SELW), .DEAD(DEAD), .SETTLE(SETTLE)) dut (
        .CLK(clk),
        .RSTN(rstn),
        .REQ_VALID(req_valid),
        .REQ_READY(req_ready),
        .REQ_SEL(req_sel),
        .REQ_OFF(req_off),
        .SW(sw),
        .BUSY(busy),
        .DONE(done),
        .ERR(err)
    );

    int nchk = 0;
    int nerr = 0;

    // Timeline model: e counts rising edges; the last request accepted at edge k
    // fixes all outputs for later cycles (kind: 0 none, 1 change, 2 no-op, 3 invalid).
    int           e = 0;
    int           k = 0;
    int           kind = 0;
    logic [N-1:0] base_sw = '0;
    logic [N-1:0] tgt = '0;
    bit           acc = 1'b0;
    logic [N-1:0] last_nz = '0;
    int           zrun = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s at edge %0d: got=%0h expected=%0h", tag, e, got, exp);
        end
    endtask

    function automatic logic [N-1:0] m_sw();
        if (kind == 1) return (e < k + DEAD_E) ? '0 : tgt;
        return base_sw;
    endfunction

    function automatic bit m_busy();
        return (kind == 1) && (e < k + DEAD_E + SET_E);
    endfunction

    function automatic bit m_done();
        return ((kind == 1) && (e == k + DEAD_E + SET_E)) || ((kind >= 2) && (e == k));
    endfunction

    function automatic bit m_err();
        return (kind == 3) && (e == k);
    endfunction

    task automatic model_edge();
        logic [N-1:0] cur;
        logic [N-1:0] t;
        bit           rdy;
        cur = m_sw();
        rdy = !m_busy();
        e++;
        acc = 1'b0;
        if (!rstn) begin
            kind    = 0;
            base_sw = '0;
            last_nz = '0;
            zrun    = 0;
        end else if (req_valid && rdy) begin
            acc     = 1'b1;
            base_sw = cur;
            k       = e;
            if (!req_off && int'(req_sel) >= N) begin
                kind = 3;
            end else begin
                t = req_off ? '0 : (N'(1) << req_sel);
                if (t == cur) begin
                    kind = 2;
                end else begin
                    kind = 1;
                    tgt  = t;
                end
            end
        end
    endtask

    task automatic compare();
        chk("sw", 32'(sw), 32'(m_sw()));
        chk("busy", 32'(busy), 32'(m_busy()));
        chk("ready", 32'(req_ready), 32'(!m_busy()));
        chk("done", 32'(done), 32'(m_done()));
        chk("err", 32'(err), 32'(m_err()));
        chk("onehot", 32'($countones(sw) <= 1), 32'(1));
        if (sw == '0) begin
            zrun++;
        end else begin
            if (last_nz != '0 && sw != last_nz) chk("bbm_gap", 32'(zrun >= DEAD_E), 32'(1));
            last_nz = sw;
            zrun    = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic req(input int sel, input bit off);
        bit got;
        got       = 1'b0;
        req_valid = 1'b1;
        req_sel   = SELW'(sel);
        req_off   = off;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (acc) begin
                got = 1'b1;
                break;
            end
        end
        req_valid = 1'b0;
        if (!got) chk("accept_timeout", 32'(0), 32'(1));
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (m_busy() && n < 50) begin
            tick();
            n++;
        end
        tick();
        if (n >= 50) chk("ready_timeout", 32'(0), 32'(1));
    endtask

    initial begin
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        repeat (10) tick();

        req(0, 1'b0); wait_ready();
        req(2, 1'b0); wait_ready();
        req(2, 1'b0); wait_ready();
        req(5, 1'b0); wait_ready();
        req(0, 1'b1);
        req(1, 1'b0); wait_ready();

        for (int ofs = 1; ofs <= DEAD_E + SET_E; ofs++) begin
            req((ofs + 2) % N, 1'b0);
            repeat (ofs - 1) tick();
            rstn = 1'b0;
            tick();
            rstn = 1'b1;
            tick();
            tick();
        end

        repeat (400) begin
            rstn      = ($urandom_range(0, 63) != 0);
            req_valid = ($urandom_range(0, 2) != 0);
            req_sel   = SELW'($urandom_range(0, 5));
            req_off   = ($urandom_range(0, 5) == 0);
            tick();
        end
        rstn      = 1'b1;
        req_valid = 1'b0;
        repeat (DEAD_E + SET_E + 3) tick();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/nsw_bbm_ctrl.md
# nsw_bbm_ctrl

Digital break-before-make sequencer that drives the `SW` control inputs of a bank of `nsw1` NMOS pass switches forming an N:1 analog mux. It accepts switch-select requests over a valid/ready handshake. For every change it opens all switches, waits a programmable dead time, then closes exactly one switch (or none). It sits directly upstream of the `nsw1` array, one `SW[i]` per switch instance, and guarantees that no two switch paths are ever shorted.

## Interface
- `N`, 4: number of `nsw1` switches driven; range 2..16.
- `SELW`, 2: width of `REQ_SEL`; must be ≥ clog2(N).
- `DEAD`, 3: break interval in CLK cycles, with all switches open; 0 is clamped to 1.
- `SETTLE`, 2: settle interval in CLK cycles after make; used only with `NSW_BBM_SETTLE_EN`; 0 is clamped to 1.

Ports:
- `CLK` input 1: the single clock; all state updates on its rising edge.
- `RSTN` input 1: synchronous, active-low reset, sampled on the `CLK` rising edge.
- `REQ_VALID` input 1: request present.
- `REQ_READY` output 1: sequencer can accept a request.
- `REQ_SEL` input SELW: index of the switch to close.
- `REQ_OFF` input 1: when 1, open all switches and ignore `REQ_SEL`.
- `SW` output N: one-hot or all-zero, registered; bit i goes to the `SW` pin of switch instance i.
- `BUSY` output 1: a sequence is in progress.
- `DONE` output 1: one-cycle pulse when a request completes.
- `ERR` output 1: one-cycle pulse when a request has `REQ_SEL` ≥ N.

## Operation
- States:
  - IDLE: `REQ_READY`=1 and `SW` holds its value.
  - BREAK: `SW`=0 while the dead-time counter runs.
  - MAKE: the new `SW` pattern is applied.
  - SETTLE: present only with the macro.
- Accept: a request is accepted on a rising edge where `REQ_VALID`&`REQ_READY`=1. `REQ_SEL` and `REQ_OFF` are captured at that edge. The requester must hold them stable until accept.
- Target: `REQ_OFF`=1 gives 0. Otherwise the target is onehot(`REQ_SEL`).
- No-op: target equal to current `SW` skips BREAK/MAKE. `DONE` pulses on the next cycle and `SW` does not glitch.
- Invalid select: `REQ_SEL` ≥ N (and `REQ_OFF`=0) is accepted. `ERR` and `DONE` pulse on the next cycle and `SW` is unchanged.
- BREAK:
  - Entered on accept of a changing request. `SW` is driven to 0 on the edge after accept.
  - The counter loads DEAD-1 and decrements each cycle. Exit to MAKE at 0.
  - BREAK also runs when the current `SW` is 0; this is required for uniform timing.
- MAKE: `SW` is driven to the target. Without the macro the sequencer goes to IDLE with `DONE`=1 for one cycle. With the macro it goes to SETTLE.
- `BUSY`=1 in BREAK, MAKE and SETTLE, and 0 in IDLE. `REQ_READY` is the complement of `BUSY`.
- Invariants:
  - popcount(`SW`) ≤ 1 in every cycle.
  - Any change between two distinct non-zero patterns passes through at least DEAD cycles of `SW`=0.
- Counter width is clog2(max(DEAD,SETTLE)+1). The counter is not free-running and does not wrap; it saturates at 0.
- Reset:
  - Values after reset: `SW`=0, `REQ_READY`=1, `BUSY`=0, `DONE`=0, `ERR`=0, state IDLE, counter 0.
  - Reset mid-sequence in any state drops `SW` to 0 at that edge and aborts the request with no `DONE`.

## Timing
- Accept at edge k:
  - `SW`=0 from edge k+1.
  - Target on `SW` from edge k+1+DEAD.
  - `DONE` high during cycle k+1+DEAD, or k+1+DEAD+SETTLE with the macro.
  - `REQ_READY` rises in the same cycle as `DONE`.
- Back-to-back: a new request may be accepted on the edge that ends the `DONE` cycle. The throughput is one request per DEAD+1 cycles (+SETTLE with the macro).
- No-op and invalid requests: `DONE` (and `ERR` for invalid) in cycle k+1, with `BUSY` never asserted.
- `REQ_VALID` while `BUSY`=1 is ignored (not queued).

## Configuration
- `NSW_BBM_SETTLE_EN` defined: the SETTLE state is compiled in. After MAKE, `BUSY` stays high and `DONE` is delayed by SETTLE cycles so the analog node settles before the requester proceeds. `SW` holds the target throughout.
- Not defined: SETTLE logic and the `SETTLE` counter load are absent and `DONE` asserts in the MAKE cycle. The `SETTLE` parameter remains declared but is unused.

## Test plan
- Reset then idle: hold `RSTN`=0 for 2 cycles and release → `SW`=0000, `REQ_READY`=1, `BUSY`=0, and no `DONE`/`ERR` for 10 cycles.
- Basic select, DEAD=3, macro off: from `SW`=0001, accept `REQ_SEL`=2 at edge k → `SW`=0000 over edges k+1..k+3, `SW`=0100 at k+4, `DONE` in cycle k+4, popcount ≤ 1 checked every cycle.
- No-op and invalid requests: with `SW`=0100, request SEL=2 → `DONE` at k+1 and `SW` never 0. Request SEL=5 with N=4 → `ERR`+`DONE` at k+1 and `SW` stays 0100.
- Off then back-to-back: `REQ_OFF`=1, then on the `DONE` cycle assert SEL=1 → `SW`=0000 for at least 3 cycles, then 0010, with each request producing exactly one `DONE` pulse.
- Reset mid-BREAK and mid-MAKE: assert `RSTN`=0 two cycles after accept → `SW`=0000 on that edge, no `DONE`, and `REQ_READY`=1 after release.
- Macro on, SETTLE=2: accept SEL=3 at k → `SW`=1000 at k+4, `BUSY` high through k+5, `DONE` in cycle k+6.
